id_ex_stage_reg_param: RTL and testbench

Parametrised, handshaked successor to the fixed-field ID/EX pipeline register. It sits between any two pipeline stages of the RV32 core (ID/EX first, then EX/MEM and MEM/WB). It carries an opaque data bundle and a control bundle with a valid bit, and supports:
- ready/valid backpressure;
- global BUSYWAIT freeze;
- FLUSH bubble insertion;
- a saturating stall-cycle counter;
- an optional two-entry skid buffer.

---
 rtl/id_ex_stage_reg_param_if.sv | 50 +++++
 rtl/id_ex_stage_reg_param.sv | 204 ++++++++++++++++++++
 tb/tb_id_ex_stage_reg_param.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_reg_param_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg_param_if
// Purpose : handshake/bus bundle for the parametrised pipeline stage register.
//           One interface carries both the upstream (in_*) and the downstream
//           (out_*) sides, plus the global stall/squash controls.
// Modports:
//   master : environment side. It drives busywait, flush, in_valid, in_data,
//            in_ctrl and out_ready. It observes in_ready, out_valid, out_data,
//            out_ctrl and stall_cnt.
//   slave  : the stage register itself (mirror of master).
// Signals :
//   busywait  global memory stall; freezes the register
//   flush     squash all held entries (branch/jump redirect)
//   in_valid  upstream entry valid
//   in_ready  register can accept an entry
//   in_data   upstream data bundle   [DATA_WIDTH]
//   in_ctrl   upstream control bundle [CTRL_WIDTH]
//   out_valid output entry valid
//   out_ready downstream accepts (hazard-unit stall when low)
//   out_data  registered data        [DATA_WIDTH]
//   out_ctrl  registered control; bubble value whenever out_valid=0
//   stall_cnt saturating count of stalled cycles [CNT_WIDTH]
// ---------------------------------------------------------------------------
interface id_ex_stage_reg_param_if #(
   parameter int unsigned DATA_WIDTH = 133,
   parameter int unsigned CTRL_WIDTH = 22,
   parameter int unsigned CNT_WIDTH  = 16
);
   logic                  busywait;
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic [CTRL_WIDTH-1:0] in_ctrl;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [CTRL_WIDTH-1:0] out_ctrl;
   logic [CNT_WIDTH-1:0]  stall_cnt;

   modport master (
      output busywait, flush, in_valid, in_data, in_ctrl, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl, stall_cnt
   );

   modport slave (
      input  busywait, flush, in_valid, in_data, in_ctrl, out_ready,
      output in_ready, out_valid, out_data, out_ctrl, stall_cnt
   );
endinterface

// File: rtl/id_ex_stage_reg_param.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg_param
// Purpose : parametrised, handshaked pipeline stage register (ID/EX, EX/MEM,
//           MEM/WB). Carries an opaque data bundle and a control bundle with
//           a valid bit. It supports ready/valid backpressure, a global
//           busywait freeze, flush bubble insertion and a saturating
//           stall-cycle counter.
// Build option:
//   PIPE_REG_SKID_EN defined   -> two-entry skid buffer (EMPTY/ONE/TWO FSM),
//                                 registered in_ready.
//   PIPE_REG_SKID_EN undefined -> single entry, in_ready combinational from
//                                 out_ready/busywait.
//   Latency is one edge in both builds.
// Ports:
//   clk    in   single clock, all state on posedge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of id_ex_stage_reg_param_if (handshake + bundles)
// ---------------------------------------------------------------------------
module id_ex_stage_reg_param #(
   parameter int unsigned            DATA_WIDTH = 133,
   parameter int unsigned            CTRL_WIDTH = 22,
   parameter logic [CTRL_WIDTH-1:0]  CTRL_NOP   = '0,
   parameter int unsigned            CNT_WIDTH  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   id_ex_stage_reg_param_if.slave    bus
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   // handshake qualifiers
   logic                  accept_c;
   logic                  drain_c;

   // output-slot update controls and source bundle
   logic                  ld_c;
   logic                  clr_c;
   logic [DATA_WIDTH-1:0] ld_data_c;
   logic [CTRL_WIDTH-1:0] ld_ctrl_c;

   // output slot
   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic [CTRL_WIDTH-1:0] out_ctrl_q;

   logic [CNT_WIDTH-1:0]  stall_cnt_q;

   // Flush beats everything; busywait blocks both directions.
   assign accept_c = bus.in_valid & bus.in_ready & ~bus.busywait & ~bus.flush;
   assign drain_c  = out_valid_q & bus.out_ready & ~bus.busywait;

`ifdef PIPE_REG_SKID_EN

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t                state_q;
   state_t                state_nxt_c;
   logic                  ld_skid_c;
   logic                  in_ready_q;
   logic [DATA_WIDTH-1:0] skid_data_q;
   logic [CTRL_WIDTH-1:0] skid_ctrl_q;

   // State register; in_ready is registered from the next state so it has
   // no combinational path from out_ready or busywait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_nxt_c;
         in_ready_q <= (state_nxt_c != ST_TWO);
      end
   end

   // Next state and slot-movement controls.
   always_comb begin
      state_nxt_c = state_q;
      ld_c        = 1'b0;
      clr_c       = 1'b0;
      ld_skid_c   = 1'b0;
      ld_data_c   = bus.in_data;
      ld_ctrl_c   = bus.in_ctrl;
      if (bus.flush) begin
         state_nxt_c = ST_EMPTY;
         clr_c       = 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept_c) begin
                  state_nxt_c = ST_ONE;
                  ld_c        = 1'b1;
               end
            end
            ST_ONE: begin
               if (accept_c && drain_c) begin
                  ld_c = 1'b1;
               end else if (accept_c) begin
                  // output slot stalled: park the newcomer in the skid slot
                  state_nxt_c = ST_TWO;
                  ld_skid_c   = 1'b1;
               end else if (drain_c) begin
                  state_nxt_c = ST_EMPTY;
                  clr_c       = 1'b1;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so only a drain can happen
               if (drain_c) begin
                  state_nxt_c = ST_ONE;
                  ld_c        = 1'b1;
                  ld_data_c   = skid_data_q;
                  ld_ctrl_c   = skid_ctrl_q;
               end
            end
            default: begin
               state_nxt_c = ST_EMPTY;
               clr_c       = 1'b1;
            end
         endcase
      end
   end

   // Skid slot; contents are don't-care once consumed or flushed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_data_q <= '0;
         skid_ctrl_q <= CTRL_NOP;
      end else if (ld_skid_c) begin
         skid_data_q <= bus.in_data;
         skid_ctrl_q <= bus.in_ctrl;
      end
   end

   assign bus.in_ready = in_ready_q;

   a_no_accept_when_full: assert property (
      @(posedge clk) disable iff (!rst_n) (state_q == ST_TWO) |-> !accept_c);

   a_valid_matches_state: assert property (
      @(posedge clk) disable iff (!rst_n) out_valid_q == (state_q != ST_EMPTY));

`else

   // Single entry: accept (possibly replacing a draining entry) or bubble out.
   always_comb begin
      ld_c      = 1'b0;
      clr_c     = 1'b0;
      ld_data_c = bus.in_data;
      ld_ctrl_c = bus.in_ctrl;
      if (bus.flush) begin
         clr_c = 1'b1;
      end else if (accept_c) begin
         ld_c = 1'b1;
      end else if (drain_c) begin
         clr_c = 1'b1;
      end
   end

   // Free when empty or when the held entry leaves this edge.
   assign bus.in_ready = ~bus.busywait & (~out_valid_q | bus.out_ready);

`endif

   // Output slot. Clearing forces the bubble control but keeps the data, so
   // downstream never sees stale write enables on an invalid entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ctrl_q  <= CTRL_NOP;
      end else if (clr_c) begin
         out_valid_q <= 1'b0;
         out_ctrl_q  <= CTRL_NOP;
      end else if (ld_c) begin
         out_valid_q <= 1'b1;
         out_data_q  <= ld_data_c;
         out_ctrl_q  <= ld_ctrl_c;
      end
   end

   // Stall counter: a valid entry that cannot leave this cycle. Saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (out_valid_q && (!bus.out_ready || bus.busywait) &&
                   (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ctrl  = out_ctrl_q;
   assign bus.stall_cnt = stall_cnt_q;

   a_bubble_ctrl: assert property (
      @(posedge clk) disable iff (!rst_n) !out_valid_q |-> (out_ctrl_q == CTRL_NOP));

endmodule

// File: tb/tb_id_ex_stage_reg_param.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg_param
// Purpose : scoreboard bench for id_ex_stage_reg_param. Stimulus pushes the
//           entries it expects to come out; a negedge monitor pops and
//           compares on every drain. Works in both builds (PIPE_REG_SKID_EN).
//           The counter is built 4 bits wide so that saturation is reachable.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg_param;

   localparam int unsigned DW = 133;
   localparam int unsigned CW = 22;
   localparam int unsigned NW = 4;

   typedef struct {
      logic [DW-1:0] data;
      logic [CW-1:0] ctrl;
   } entry_t;

   logic   clk   = 1'b0;
   logic   rst_n = 1'b0;
   entry_t exp_q[$];
   int     n_cmp = 0;
   int     n_bad = 0;
   int     n_drained = 0;

   always #5 clk = ~clk;

   id_ex_stage_reg_param_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) bus ();

   id_ex_stage_reg_param #(
      .DATA_WIDTH (DW),
      .CTRL_WIDTH (CW),
      .CTRL_NOP   ('0),
      .CNT_WIDTH  (NW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   function automatic logic [DW-1:0] mk(input logic [31:0] pc, input logic [31:0] d1,
                                        input logic [31:0] d2, input logic [31:0] imm);
      return {5'd0, pc, d1, d2, imm};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.in_ctrl  = c;
   endtask

   task automatic expect_out(input logic [DW-1:0] d, input logic [CW-1:0] c);
      entry_t e;
      e.data = d;
      e.ctrl = c;
      exp_q.push_back(e);
   endtask

   // Monitor: inputs are stable at negedge, so this sees exactly the entry
   // that leaves at the next posedge.
   always @(negedge clk) begin
      entry_t e;
      if (rst_n && bus.out_valid && bus.out_ready && !bus.busywait && !bus.flush) begin
         n_drained++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_unexpected: actual data %0h required no entry", bus.out_data);
         end else begin
            e = exp_q.pop_front();
            chk("drain_data", bus.out_data, e.data);
            chk("drain_ctrl", DW'(bus.out_ctrl), DW'(e.ctrl));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] a, b1, b2, c1, c2, c3, d, e, f, g;
      a  = mk(32'd23, 32'd45, 32'd33, 32'd56);
      b1 = mk(32'h100, 32'h1, 32'h2, 32'h3);
      b2 = mk(32'h104, 32'h4, 32'h5, 32'h6);
      c1 = mk(32'h200, 32'hA, 32'hB, 32'hC);
      c2 = mk(32'h204, 32'hD, 32'hE, 32'hF);
      c3 = mk(32'h208, 32'h11, 32'h12, 32'h13);
      d  = mk(32'h300, 32'h21, 32'h22, 32'h23);
      e  = mk(32'h400, 32'h31, 32'h32, 32'h33);
      f  = mk(32'h500, 32'h41, 32'h42, 32'h43);
      g  = mk(32'h600, 32'h51, 32'h52, 32'h53);

      bus.busywait  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b0, '0, '0);

      // reset values
      #1;
      chk("rst_out_valid", DW'(bus.out_valid), DW'(0));
      chk("rst_out_ctrl",  DW'(bus.out_ctrl),  DW'(0));
      chk("rst_out_data",  bus.out_data,       DW'(0));
      chk("rst_stall_cnt", DW'(bus.stall_cnt), DW'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("rst_in_ready", DW'(bus.in_ready), DW'(1));

      // pass-through
      drive(1'b1, a, 22'h15);
      expect_out(a, 22'h15);
      step();
      chk("pass_valid", DW'(bus.out_valid), DW'(1));
      chk("pass_data",  bus.out_data, a);
      chk("pass_ctrl",  DW'(bus.out_ctrl), DW'(22'h15));

      // busywait hold for three edges with a new input presented
      bus.busywait = 1'b1;
      drive(1'b1, mk(32'd43, 32'd55, 32'd0, 32'd0), 22'h2A);
`ifndef PIPE_REG_SKID_EN
      #1;
      chk("bw_in_ready", DW'(bus.in_ready), DW'(0));
`endif
      repeat (3) step();
      chk("bw_hold_data",  bus.out_data, a);
      chk("bw_hold_ctrl",  DW'(bus.out_ctrl), DW'(22'h15));
      chk("bw_stall_cnt",  DW'(bus.stall_cnt), DW'(3));
      bus.busywait = 1'b0;
      drive(1'b0, '0, '0);
      step();
      chk("bw_drain_valid", DW'(bus.out_valid), DW'(0));
      chk("bw_drain_ctrl",  DW'(bus.out_ctrl), DW'(0));

      // backpressure: push B1 then B2 with out_ready low
      bus.out_ready = 1'b0;
      drive(1'b1, b1, 22'h101);
      expect_out(b1, 22'h101);
      step();
      drive(1'b1, b2, 22'h102);
`ifdef PIPE_REG_SKID_EN
      expect_out(b2, 22'h102);
      step();
      chk("bp_in_ready_full", DW'(bus.in_ready), DW'(0));
      drive(1'b0, '0, '0);
      bus.out_ready = 1'b1;
      step();
      chk("bp_in_ready_after_drain", DW'(bus.in_ready), DW'(1));
      chk("bp_second_data", bus.out_data, b2);
      step();
`else
      #1;
      chk("bp_in_ready_full", DW'(bus.in_ready), DW'(0));
      step();
      chk("bp_hold_first", bus.out_data, b1);
      bus.out_ready = 1'b1;
      #1;
      chk("bp_in_ready_release", DW'(bus.in_ready), DW'(1));
      expect_out(b2, 22'h102);
      step();
      chk("bp_second_data", bus.out_data, b2);
      drive(1'b0, '0, '0);
      step();
`endif
      chk("bp_empty", DW'(bus.out_valid), DW'(0));
      chk("bp_stall_cnt", DW'(bus.stall_cnt), DW'(4));

      // flush with a same-cycle input
      bus.out_ready = 1'b0;
      drive(1'b1, c1, 22'h201);
      step();
      drive(1'b1, c2, 22'h202);
      step();
      bus.flush = 1'b1;
      drive(1'b1, c3, 22'h203);
      exp_q.delete();
      step();
      chk("fl_valid",    DW'(bus.out_valid), DW'(0));
      chk("fl_ctrl_nop", DW'(bus.out_ctrl), DW'(0));
      chk("fl_data_kept", bus.out_data, c1);
      chk("fl_in_ready", DW'(bus.in_ready), DW'(1));
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b1, d, 22'h301);
      expect_out(d, 22'h301);
      step();
      chk("fl_next_valid", DW'(bus.out_valid), DW'(1));
      chk("fl_next_data",  bus.out_data, d);
      drive(1'b0, '0, '0);
      step();
      chk("fl_stall_cnt", DW'(bus.stall_cnt), DW'(6));

      // saturation: 20 stalled edges on a 4-bit counter starting at 6
      bus.out_ready = 1'b0;
      drive(1'b1, e, 22'h3FF);
      expect_out(e, 22'h3FF);
      step();
      drive(1'b0, '0, '0);
      repeat (8) step();
      chk("sat_cnt_14", DW'(bus.stall_cnt), DW'(14));
      step();
      chk("sat_cnt_15", DW'(bus.stall_cnt), DW'(15));
      repeat (11) step();
      chk("sat_no_wrap", DW'(bus.stall_cnt), DW'(15));
      chk("sat_data_held", bus.out_data, e);
      bus.out_ready = 1'b1;
      step();

      // asynchronous reset mid-stream
      bus.out_ready = 1'b0;
      drive(1'b1, f, 22'h3);
      step();
      drive(1'b0, '0, '0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", DW'(bus.out_valid), DW'(0));
      chk("mrst_out_ctrl",  DW'(bus.out_ctrl),  DW'(0));
      chk("mrst_out_data",  bus.out_data,       DW'(0));
      chk("mrst_stall_cnt", DW'(bus.stall_cnt), DW'(0));
      exp_q.delete();
      bus.out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("mrst_in_ready", DW'(bus.in_ready), DW'(1));

      // normal operation after reset
      drive(1'b1, g, 22'h155);
      expect_out(g, 22'h155);
      step();
      chk("post_valid", DW'(bus.out_valid), DW'(1));
      chk("post_data",  bus.out_data, g);
      drive(1'b0, '0, '0);
      step();
      step();
      chk("sb_empty",    DW'(exp_q.size()), DW'(0));
      chk("sb_drained",  DW'(n_drained),    DW'(6));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
